// File: rtl/tt_um_emern_cmd_scheduler.sv
// Command scheduler: queues decoded SPI commands in a small FIFO, gates SPI
// loading to horizontal blanking and commits queued commands during vblank.
module tt_um_emern_cmd_scheduler #(
  parameter int DEPTH = 4,
  parameter int CMD_W = 53
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [9:0]               hpos,
  input  logic [9:0]               vpos,
  input  logic                     display_on,
  input  logic                     cmd_valid,
  input  logic [CMD_W-1:0]         cmd_data,
  output logic                     en_load,
  output logic                     commit_valid,
  output logic [CMD_W-1:0]         commit_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VB,
    DRAIN
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CMD_W-1:0]   mem [DEPTH];
  logic               hblank;
  logic               vblank;
  logic               full;
  logic               empty;
  logic               pop;
  logic               push;

  assign hblank = (hpos >= 10'd640) | ~display_on;
  assign vblank = (vpos >= 10'd480) | ~display_on;
  assign full   = (fifo_level == FULL_LVL);
  assign empty  = (fifo_level == '0);

  // A full FIFO still accepts a command when the head leaves in the same cycle.
  assign push = cmd_valid & (~full | pop);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (!empty) state_next = WAIT_VB;
      WAIT_VB: if (vblank) state_next = DRAIN;
      DRAIN: begin
        if (!vblank)    state_next = WAIT_VB;
        else if (empty) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic: a pop is only ever decided inside vblank
  always_comb begin
    pop = 1'b0;
    if (state == DRAIN) pop = vblank & ~empty;
  end

  // FIFO bookkeeping
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (cmd_valid && !push) overflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; the pointers and level define
  // which entries are meaningful, so a flush only needs to clear those.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd_data;
  end

  // Commit strobe and data, registered one cycle after the pop decision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_valid <= 1'b0;
      commit_data  <= '0;
    end else begin
      commit_valid <= pop;
      if (pop) commit_data <= mem[rd_ptr];
    end
  end

  // SPI load enable lags hblank by one cycle and stops while the queue is full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_load <= 1'b0;
    else        en_load <= hblank & ~full;
  end

endmodule

// File: tb/tb_tt_um_emern_cmd_scheduler.sv
// Self-checking bench for the command scheduler: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_tt_um_emern_cmd_scheduler;

  localparam int DEPTH = 4;
  localparam int CMD_W = 53;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_DRAIN = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [9:0]        hpos = 10'd0;
  logic [9:0]        vpos = 10'd0;
  logic              display_on = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [CMD_W-1:0]  cmd_data = '0;
  logic              en_load;
  logic              commit_valid;
  logic [CMD_W-1:0]  commit_data;
  logic [2:0]        fifo_level;
  logic              overflow;

  tt_um_emern_cmd_scheduler #(.DEPTH(DEPTH), .CMD_W(CMD_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hpos         (hpos),
    .vpos         (vpos),
    .display_on   (display_on),
    .cmd_valid    (cmd_valid),
    .cmd_data     (cmd_data),
    .en_load      (en_load),
    .commit_valid (commit_valid),
    .commit_data  (commit_data),
    .fifo_level   (fifo_level),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [CMD_W-1:0] mq[$];
  int               m_state;
  bit               m_en_load;
  bit               m_commit_valid;
  logic [CMD_W-1:0] m_commit_data;
  bit               m_overflow;

  // Commits observed on the DUT since the last clear
  logic [CMD_W-1:0] got_q[$];
  logic [CMD_W-1:0] sent_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_state        = M_IDLE;
    m_en_load      = 1'b0;
    m_commit_valid = 1'b0;
    m_commit_data  = '0;
    m_overflow     = 1'b0;
  endtask

  // One clock of the scheduler rules, evaluated on the inputs held this cycle
  task automatic model_update();
    bit hb, vb, pop, push;
    int lvl;
    lvl  = mq.size();
    hb   = (hpos >= 640) || !display_on;
    vb   = (vpos >= 480) || !display_on;
    pop  = (m_state == M_DRAIN) && vb && (lvl != 0);
    push = cmd_valid && ((lvl < DEPTH) || pop);
    m_en_load = hb && (lvl < DEPTH);
    case (m_state)
      M_IDLE:  if (lvl != 0) m_state = M_WAIT;
      M_WAIT:  if (vb) m_state = M_DRAIN;
      default: begin
        if (!vb)           m_state = M_WAIT;
        else if (lvl == 0) m_state = M_IDLE;
      end
    endcase
    m_commit_valid = pop;
    if (pop) m_commit_data = mq.pop_front();
    if (push)           mq.push_back(cmd_data);
    else if (cmd_valid) m_overflow = 1'b1;
  endtask

  task automatic compare_all();
    check("en_load", 64'(en_load), 64'(m_en_load));
    check("commit_valid", 64'(commit_valid), 64'(m_commit_valid));
    if (m_commit_valid) check("commit_data", 64'(commit_data), 64'(m_commit_data));
    check("fifo_level", 64'(fifo_level), 64'(mq.size()));
    check("overflow", 64'(overflow), 64'(m_overflow));
  endtask

  // Inputs are changed at the falling edge; outputs are compared there too.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
    if (commit_valid) got_q.push_back(commit_data);
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_en_load", 64'(en_load), 64'(0));
    check("rst_commit_valid", 64'(commit_valid), 64'(0));
    check("rst_commit_data", 64'(commit_data), 64'(0));
    check("rst_fifo_level", 64'(fifo_level), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    sent_q.delete();
  endtask

  task automatic push_cmd(input logic [CMD_W-1:0] d);
    cmd_valid = 1'b1;
    cmd_data  = d;
    sent_q.push_back(d);
    step();
    cmd_valid = 1'b0;
  endtask

  function automatic logic [CMD_W-1:0] rand_cmd(input logic [7:0] op);
    logic [CMD_W-1:0] d;
    d = {$urandom, $urandom};
    d[7:0] = op;
    return d;
  endfunction

  initial begin
    int n;
    bit seen;

    // Reset / idle: en_load rises one cycle after release in hblank
    @(negedge clk);
    hpos = 10'd700;
    vpos = 10'd100;
    apply_reset();
    step();
    check("en_load_after_release", 64'(en_load), 64'(1));

    // Gating sweep: en_load follows hblank with one cycle of lag
    begin
      int hs[4] = '{639, 640, 799, 0};
      bit ex[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
        hpos = 10'(hs[i]);
        step();
        check($sformatf("sweep_en_load_%0d", hs[i]), 64'(en_load), 64'(ex[i]));
      end
    end

    // Fill to DEPTH, then one more push overflows; en_load drops while full
    hpos = 10'd700;
    vpos = 10'd10;
    for (int i = 0; i < DEPTH; i++) push_cmd(rand_cmd(8'(8'h10 + i)));
    step();
    check("full_en_load", 64'(en_load), 64'(0));
    push_cmd(rand_cmd(8'hEE));
    check("full_level", 64'(fifo_level), 64'(DEPTH));
    check("full_overflow", 64'(overflow), 64'(1));
    vpos = 10'd480;
    for (int i = 0; i < 10; i++) step();
    check("ovf_commit_count", 64'(got_q.size()), 64'(DEPTH));
    for (int i = 0; i < DEPTH && i < got_q.size(); i++)
      check($sformatf("ovf_commit_%0d", i), 64'(got_q[i]), 64'(sent_q[i]));

    // Deferred commit: nothing leaves the queue during active video
    apply_reset();
    vpos = 10'd100;
    push_cmd(rand_cmd(8'h80));
    push_cmd(rand_cmd(8'h81));
    for (int i = 0; i < 6; i++) step();
    check("deferred_no_commit", 64'(got_q.size()), 64'(0));
    vpos = 10'd480;
    for (int i = 0; i < 6; i++) step();
    check("deferred_count", 64'(got_q.size()), 64'(2));
    if (got_q.size() == 2) begin
      check("deferred_first", 64'(got_q[0]), 64'(sent_q[0]));
      check("deferred_second", 64'(got_q[1]), 64'(sent_q[1]));
    end
    check("deferred_level", 64'(fifo_level), 64'(0));

    // Vblank boundary: stop after two commits, resume next vblank
    apply_reset();
    vpos = 10'd10;
    for (int i = 0; i < 4; i++) push_cmd(rand_cmd(8'(8'h40 + i)));
    vpos = 10'd524;
    n = 0;
    while (got_q.size() < 2 && n < 20) begin
      step();
      n++;
    end
    check("boundary_reached_two", 64'(got_q.size()), 64'(2));
    vpos = 10'd0;
    for (int i = 0; i < 5; i++) step();
    check("boundary_stopped", 64'(got_q.size()), 64'(2));
    check("boundary_level", 64'(fifo_level), 64'(2));
    vpos = 10'd480;
    for (int i = 0; i < 6; i++) step();
    check("boundary_resume", 64'(got_q.size()), 64'(4));
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check($sformatf("boundary_order_%0d", i), 64'(got_q[i]), 64'(sent_q[i]));

    // Display off: minimum latency of three cycles
    apply_reset();
    display_on = 1'b0;
    vpos = 10'd200;
    push_cmd(rand_cmd(8'hA5));
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      step();
      n++;
      seen = commit_valid;
    end
    check("latency_cycles", 64'(n), 64'(3));

    // Reset mid-drain flushes the queue without a clock
    display_on = 1'b1;
    for (int i = 0; i < 3; i++) push_cmd(rand_cmd(8'(8'hC0 + i)));
    display_on = 1'b0;
    step();
    step();
    check("middrain_commit", 64'(commit_valid), 64'(1));
    apply_reset();
    for (int i = 0; i < 6; i++) step();
    check("middrain_no_commits", 64'(got_q.size()), 64'(0));

    // Randomized traffic
    display_on = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      hpos = 10'($urandom_range(0, 799));
      if ($urandom_range(0, 19) == 0) vpos = 10'($urandom_range(0, 524));
      if ($urandom_range(0, 63) == 0) display_on = ~display_on;
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_data  = {$urandom, $urandom};
      if ($urandom_range(0, 499) == 0) begin
        cmd_valid = 1'b0;
        apply_reset();
      end else begin
        step();
      end
    end
    cmd_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_um_emern_cmd_scheduler.md
# tt_um_emern_cmd_scheduler

Command scheduler between the SPI frontend's command decoder and the polygon/background register bank. Queues decoded 53-bit commands in a small FIFO and gates SPI loading to horizontal blanking, so SPI traffic never disturbs active video. Commits queued commands to the register bank one per cycle, only during vertical blanking or while the display is off, so a frame never renders half-updated geometry.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..8.
- CMD_W, 53: command width; bits [7:0] are the cmd byte, [52:8] the payload, same packing as the SPI frontend buffer.
- clk  in  1  system/pixel clock.
- rst_n  in  1  reset; asynchronous, active-low.
- hpos  in  10  current VGA column, 0..799; visible when < 640.
- vpos  in  10  current VGA line, 0..524; visible when < 480.
- display_on  in  1  screen enabled; 0 = blanking treated as permanently active.
- cmd_valid  in  1  one-cycle pulse: frontend finished a command.
- cmd_data  in  CMD_W  command accompanying cmd_valid.
- en_load  out  1  SPI load enable to the frontend.
- commit_valid  out  1  one-cycle strobe: commit_data must be applied to the register bank.
- commit_data  out  CMD_W  command being committed.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a command was dropped because the FIFO was full.

## Operation
- hblank = (hpos >= 640) | ~display_on; vblank = (vpos >= 480) | ~display_on.
- en_load register: next value = hblank & (fifo_level < DEPTH). SPI shifting stops while the queue is full.
- Push: on cmd_valid, write cmd_data at the write pointer if the FIFO is not full or a pop happens in the same cycle. Otherwise drop the command and set overflow. Only reset clears overflow.
- Pointers wrap modulo DEPTH. fifo_level = pushes − pops, with simultaneous push+pop leaving the level unchanged.
- FSM states: IDLE, WAIT_VB, DRAIN.
  - IDLE: if fifo_level != 0, go to WAIT_VB.
  - WAIT_VB: if vblank, go to DRAIN.
  - DRAIN: if ~vblank, go to WAIT_VB; no pop that cycle. Else if fifo_level != 0, pop the head into commit_data and assert commit_valid the next cycle. Else go to IDLE.
- FIFO order is strictly preserved. A command arriving during DRAIN is committed in the same blanking interval if vblank is still active.
- The scheduler does not decode commands. Unknown cmd bytes pass through unchanged.

## Timing
- Reset values: state = IDLE, pointers = 0, fifo_level = 0, en_load = 0, commit_valid = 0, commit_data = 0, overflow = 0.
- Reset asserted mid-drain flushes the FIFO immediately. Queued commands are lost and commit_valid drops with no clock needed.
- en_load lags hblank by 1 cycle.
- Minimum latency is 3 cycles: cmd_valid at edge t with FIFO empty, state IDLE and vblank active. At t+1, level = 1 and state = WAIT_VB. At t+2, state = DRAIN. The pop is decided at t+2, so commit_valid = 1 after edge t+3.
- Drain throughput is 1 command per cycle. commit_valid is never high in two cycles for the same entry.
- A pop is never decided while vblank = 0. After vblank drops, at most 1 further commit_valid can appear: the one registered from the prior pop.
- A push and a pop in the same cycle at fifo_level == DEPTH is accepted and does not set overflow.

## Test plan
- Reset/idle: rst_n low → all outputs 0. Release with hpos = 700, display_on = 1 → en_load = 1 one cycle later.
- Gating: hpos sweeps 639→640→799→0 → en_load goes 0→1→1→0, each with 1-cycle lag. Fill the FIFO to 4 → en_load = 0 even at hpos = 700.
- Deferred commit: push 0x…80 and 0x…81 at vpos = 100 → no commit_valid until vpos = 480. Then two consecutive commit_valid pulses in push order, and fifo_level returns to 0.
- Overflow: 5 pushes at vpos = 10 → fifo_level = 4, overflow = 1. At vblank, exactly the first 4 commands are committed.
- Vblank boundary: 4 queued, vpos goes 524→0 after 2 commits → commits stop. The remaining 2 commit at the next vpos = 480.
- Display off: display_on = 0, push at vpos = 200 → commit_valid after 3 cycles. Assert rst_n mid-drain with 3 queued → level 0, no further commits.
